enemy_tile_lookup: RTL and testbench
====================================

Name: enemy_tile_lookup

Overview:
Upstream feeder for the four-enemy movement controller. Once per frame it computes the map tile under each enemy's centre and reads that tile's code from the shared tilemap RAM through a request/grant port. It then presents a stable tileN_addr/tileN_code pair per enemy, which the movement controller samples on its next frame_tick.

Parameters:
SCR_W, 1920, screen width in pixels
SCR_H, 1080, screen height in pixels
MAP_W, 48, map columns
MAP_H, 27, map rows
TILE_W, 40, tile edge in pixels (square tiles)
ENEMY_SIZE, 40, enemy sprite edge in pixels
MAP_RD_LAT, 1, map RAM read latency in cycles after grant (>=1)

Ports:
clk_pix  in  1  pixel clock, 148.5 MHz
rstn  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame
game_reset  in  1  round restart
enemy0_x..enemy3_x  in  12 each  enemy X positions in pixels
enemy0_y..enemy3_y  in  12 each  enemy Y positions in pixels
map_req  out  1  map read request
map_addr  out  11  map read address
map_gnt  in  1  map read grant
map_code  in  4  map read data (1=WALL, 2=COIN, 0=BG)
tile0_addr..tile3_addr  out  11 each  tile index under each enemy's centre
tile0_code..tile3_code  out  4 each  code of that tile
busy  out  1  sweep in progress
lookup_done  out  1  one-cycle pulse when all four slots are updated

Behaviour:
- Reset (rstn=0): all tileN_addr=0, tileN_code=0, map_req=0, map_addr=0, busy=0, lookup_done=0, pending=0, state IDLE.
- Probe point: px = x + ENEMY_SIZE/2, py = y + ENEMY_SIZE/2.
- col = floor(px / TILE_W), clamped to MAP_W-1.
- row = floor(py / TILE_W), clamped to MAP_H-1.
- addr = row*MAP_W + col, 11 bits. The result must be an exact floor; an iterative or reciprocal-multiply implementation is allowed only if it is bit-exact over px in 0..SCR_W+19.
- States:
  - IDLE: on frame_tick, latch all eight position inputs into a snapshot; slot=0; go to CALC.
  - CALC (1 cycle): compute addr for the current slot from the snapshot.
  - REQ: map_req=1 and map_addr=addr. Hold both stable until map_gnt=1 is sampled.
  - WAIT (MAP_RD_LAT cycles, map_req=0): on the last cycle, capture map_code. tileN_addr and tileN_code for that slot update on the same edge. If slot<3, increment slot and go to CALC; otherwise go to DONE.
  - DONE (1 cycle): lookup_done=1. If pending, clear it and restart the sweep (same as IDLE with a tick, re-latching positions); otherwise go to IDLE.
- busy=1 in every state except IDLE.
- Timing with map_gnt tied to 1: each slot takes 2+MAP_RD_LAT cycles. For a tick in cycle T, lookup_done is high in cycle T+1+4*(2+MAP_RD_LAT), which is T+13 at the default latency.
- frame_tick while busy: set pending, keeping at most one. The running sweep continues on its original snapshot.
- game_reset (any state, priority over frame_tick):
  - map_req=0; state IDLE; pending=0.
  - All tileN_code=0, so enemies are not falsely wall-blocked after respawn. tileN_addr are held.
  - An in-flight read result is discarded.
- Only outputs of the slot being captured change; the other slots hold their values.

Optional Feature:
PAC_PROBE_EN:
- Defined: adds inputs pac_x and pac_y (12 bits each) and outputs pac_tile_addr (11) and pac_tile_code (4). The sweep gains a fifth slot (index 4, after enemy3). lookup_done moves to T+1+5*(2+MAP_RD_LAT). pac_tile_code is cleared on game_reset like the enemy codes.
- Undefined: four slots only, and these ports are absent.

Decomposition:
- Shared package (game_pkg): SCR_W, SCR_H, MAP_W, MAP_H, TILE_W; tile code constants TILE_BG=0, TILE_WALL=1, TILE_COIN=2; FSM state enum.
- Sub-module px_to_tile: combinational px/py -> clamped addr. Reused by the pacman controller.

Test Plan:
1. Positions (0,0), (1880,0), (0,1040), (1880,1040); gnt=1; RAM returns addr[3:0]; tick -> tile addrs 0, 47, 1248, 1295; codes 0, 15, 0, 15; lookup_done at T+13.
2. enemy0_x=19 gives addr 0; enemy0_x=20 gives addr 1; enemy0_y=20 gives addr 48. Drive x=1919 -> col clamped to 47.
3. map_gnt held low 5 cycles in slot 1 -> map_req and map_addr stable throughout; lookup_done at T+18.
4. Second frame_tick at T+4 -> single restart after DONE, using positions re-latched at T+13; exactly two lookup_done pulses.
5. game_reset at T+7 -> map_req=0 next cycle, all codes=0, busy=0, no lookup_done; next tick starts a clean sweep.
6. rstn asserted mid-REQ -> all outputs 0 immediately (asynchronous); after release, no activity until frame_tick.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game geometry, tile codes and lookup FSM states
//
// Purpose: constants shared by the enemy/pacman tile lookup blocks.
// Ports:   none (package).
// Config:  PAC_PROBE_EN adds a fifth lookup slot for the pacman probe.
package game_pkg;

  localparam int SCR_W      = 1920;
  localparam int SCR_H      = 1080;
  localparam int MAP_W      = 48;
  localparam int MAP_H      = 27;
  localparam int TILE_W     = 40;
  localparam int ENEMY_SIZE = 40;
  localparam int MAP_RD_LAT = 1;

  localparam logic [3:0] TILE_BG   = 4'd0;
  localparam logic [3:0] TILE_WALL = 4'd1;
  localparam logic [3:0] TILE_COIN = 4'd2;

`ifdef PAC_PROBE_EN
  localparam int NUM_SLOTS = 5;
`else
  localparam int NUM_SLOTS = 4;
`endif
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int LAT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lookup_state_t;

endpackage

// File: rtl/enemy_tile_lookup_if.sv
// rtl/enemy_tile_lookup_if.sv - tilemap RAM request/grant read port
//
// Purpose: groups the shared tilemap read port.
// Signals: map_req/map_addr (requester -> RAM), map_gnt/map_code (RAM -> requester).
// Modports: master = lookup side, slave = RAM/arbiter side.
interface enemy_tile_lookup_if;
  logic        map_req;
  logic [10:0] map_addr;
  logic        map_gnt;
  logic [3:0]  map_code;

  modport master (
    output map_req,
    output map_addr,
    input  map_gnt,
    input  map_code
  );

  modport slave (
    input  map_req,
    input  map_addr,
    output map_gnt,
    output map_code
  );
endinterface

// File: rtl/enemy_tile_lookup_px_to_tile.sv
// rtl/enemy_tile_lookup_px_to_tile.sv - sprite position to clamped map tile index
//
// Purpose: combinational map from a sprite's top-left pixel position to the
//          index of the tile under its centre, clamped to the map edge.
// Ports:   pos_x, pos_y (12b pixel position) -> tile_addr (11b row*MAP_W+col).
module px_to_tile
  import game_pkg::*;
(
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  output logic [10:0] tile_addr
);

  logic [12:0] px;
  logic [12:0] py;
  logic [12:0] col_raw;
  logic [12:0] row_raw;
  logic [5:0]  col;
  logic [4:0]  row;

  always_comb begin
    px = {1'b0, pos_x} + 13'(ENEMY_SIZE / 2);
    py = {1'b0, pos_y} + 13'(ENEMY_SIZE / 2);
    // Division by a constant: exact floor for the whole 13-bit range.
    col_raw = px / 13'(TILE_W);
    row_raw = py / 13'(TILE_W);
    col = (col_raw > 13'(MAP_W - 1)) ? 6'(MAP_W - 1) : col_raw[5:0];
    row = (row_raw > 13'(MAP_H - 1)) ? 5'(MAP_H - 1) : row_raw[4:0];
    tile_addr = 11'(row) * 11'(MAP_W) + 11'(col);
  end

endmodule

// File: rtl/enemy_tile_lookup.sv
// rtl/enemy_tile_lookup.sv - per-frame tile code lookup for the four enemies
//
// Purpose: on each frame_tick snapshot the enemy positions, then for each slot
//          compute the tile under the sprite centre, read its code through the
//          shared map port and publish a stable tileN_addr/tileN_code pair.
// Ports:   clk_pix, rstn (async active-low), frame_tick, game_reset,
//          enemy0..3_x/y (12b), map (enemy_tile_lookup_if.master),
//          tile0..3_addr (11b), tile0..3_code (4b), busy, lookup_done.
// Config:  PAC_PROBE_EN adds pac_x/pac_y inputs and pac_tile_addr/pac_tile_code
//          outputs, swept as a fifth slot after enemy3.
module enemy_tile_lookup
  import game_pkg::*;
(
  input  logic                       clk_pix,
  input  logic                       rstn,
  input  logic                       frame_tick,
  input  logic                       game_reset,
  input  logic [11:0]                enemy0_x,
  input  logic [11:0]                enemy0_y,
  input  logic [11:0]                enemy1_x,
  input  logic [11:0]                enemy1_y,
  input  logic [11:0]                enemy2_x,
  input  logic [11:0]                enemy2_y,
  input  logic [11:0]                enemy3_x,
  input  logic [11:0]                enemy3_y,
`ifdef PAC_PROBE_EN
  input  logic [11:0]                pac_x,
  input  logic [11:0]                pac_y,
  output logic [10:0]                pac_tile_addr,
  output logic [3:0]                 pac_tile_code,
`endif
  enemy_tile_lookup_if.master        map,
  output logic [10:0]                tile0_addr,
  output logic [10:0]                tile1_addr,
  output logic [10:0]                tile2_addr,
  output logic [10:0]                tile3_addr,
  output logic [3:0]                 tile0_code,
  output logic [3:0]                 tile1_code,
  output logic [3:0]                 tile2_code,
  output logic [3:0]                 tile3_code,
  output logic                       busy,
  output logic                       lookup_done
);

  lookup_state_t     state;
  lookup_state_t     state_nxt;
  logic              latch;
  logic              capture;
  logic              last_lat;
  logic              last_slot;

  logic [SLOT_W-1:0] slot;
  logic [LAT_W-1:0]  lat_cnt;
  logic              pending;
  logic [10:0]       addr_q;
  logic [10:0]       calc_addr;

  logic [11:0]       pos_x_in [NUM_SLOTS];
  logic [11:0]       pos_y_in [NUM_SLOTS];
  logic [11:0]       snap_x   [NUM_SLOTS];
  logic [11:0]       snap_y   [NUM_SLOTS];
  logic [10:0]       tile_addr_q [NUM_SLOTS];
  logic [3:0]        tile_code_q [NUM_SLOTS];

  assign pos_x_in[0] = enemy0_x;
  assign pos_y_in[0] = enemy0_y;
  assign pos_x_in[1] = enemy1_x;
  assign pos_y_in[1] = enemy1_y;
  assign pos_x_in[2] = enemy2_x;
  assign pos_y_in[2] = enemy2_y;
  assign pos_x_in[3] = enemy3_x;
  assign pos_y_in[3] = enemy3_y;
`ifdef PAC_PROBE_EN
  assign pos_x_in[4] = pac_x;
  assign pos_y_in[4] = pac_y;
`endif

  px_to_tile u_px_to_tile (
    .pos_x     (snap_x[slot]),
    .pos_y     (snap_y[slot]),
    .tile_addr (calc_addr)
  );

  assign last_lat  = (lat_cnt == LAT_W'(MAP_RD_LAT - 1));
  assign last_slot = (slot == SLOT_W'(NUM_SLOTS - 1));

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    latch       = 1'b0;
    capture     = 1'b0;
    busy        = (state != ST_IDLE);
    lookup_done = (state == ST_DONE);
    if (game_reset) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            latch     = 1'b1;
            state_nxt = ST_CALC;
          end
        end
        ST_CALC: state_nxt = ST_REQ;
        ST_REQ: begin
          if (map.map_gnt) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (last_lat) begin
            capture   = 1'b1;
            state_nxt = last_slot ? ST_DONE : ST_CALC;
          end
        end
        ST_DONE: begin
          // A tick arriving in DONE itself is honoured like a pending one.
          if (pending || frame_tick) begin
            latch     = 1'b1;
            state_nxt = ST_CALC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign map.map_req  = (state == ST_REQ);
  assign map.map_addr = addr_q;

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      slot    <= '0;
      lat_cnt <= '0;
      pending <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        snap_x[i]      <= '0;
        snap_y[i]      <= '0;
        tile_addr_q[i] <= '0;
        tile_code_q[i] <= '0;
      end
    end else if (game_reset) begin
      // Addresses are kept; codes are cleared so nothing reads as a wall.
      pending <= 1'b0;
      lat_cnt <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) tile_code_q[i] <= TILE_BG;
    end else begin
      if (latch) begin
        // Only a tick seen in the DONE restart cycle itself survives.
        pending <= (state == ST_DONE) && pending && frame_tick;
        slot    <= '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          snap_x[i] <= pos_x_in[i];
          snap_y[i] <= pos_y_in[i];
        end
      end else if (frame_tick && busy) begin
        pending <= 1'b1;
      end

      if (state == ST_CALC) begin
        addr_q  <= calc_addr;
        lat_cnt <= '0;
      end

      if (state == ST_WAIT) lat_cnt <= lat_cnt + 1'b1;

      if (capture) begin
        tile_addr_q[slot] <= addr_q;
        tile_code_q[slot] <= map.map_code;
        if (!last_slot) slot <= slot + 1'b1;
      end
    end
  end

  assign tile0_addr = tile_addr_q[0];
  assign tile1_addr = tile_addr_q[1];
  assign tile2_addr = tile_addr_q[2];
  assign tile3_addr = tile_addr_q[3];
  assign tile0_code = tile_code_q[0];
  assign tile1_code = tile_code_q[1];
  assign tile2_code = tile_code_q[2];
  assign tile3_code = tile_code_q[3];
`ifdef PAC_PROBE_EN
  assign pac_tile_addr = tile_addr_q[4];
  assign pac_tile_code = tile_code_q[4];
`endif

endmodule

// File: tb/tb_enemy_tile_lookup.sv
// tb/tb_enemy_tile_lookup.sv - self-checking bench for enemy_tile_lookup
module tb_enemy_tile_lookup;
  import game_pkg::*;

  localparam int SWEEP_LAT = 1 + NUM_SLOTS * (2 + MAP_RD_LAT);

  logic        clk_pix = 1'b0;
  logic        rstn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        game_reset = 1'b0;
  logic        busy;
  logic        lookup_done;
  logic [11:0] pos_x [NUM_SLOTS];
  logic [11:0] pos_y [NUM_SLOTS];
  logic [10:0] t_addr [NUM_SLOTS];
  logic [3:0]  t_code [NUM_SLOTS];

  int          exp_x [NUM_SLOTS];
  int          exp_y [NUM_SLOTS];
  int          old_addr [NUM_SLOTS];
  logic [3:0]  map_mem [0:2047];
  bit          rand_gnt = 1'b0;

  int checks = 0;
  int errors = 0;

  enemy_tile_lookup_if mif ();

  always #5 clk_pix = ~clk_pix;

  // Tilemap RAM: data for a granted address appears on the next edge and holds.
  always @(posedge clk_pix) begin
    if (mif.map_req && mif.map_gnt) mif.map_code <= map_mem[mif.map_addr];
  end

  enemy_tile_lookup dut (
    .clk_pix     (clk_pix),
    .rstn        (rstn),
    .frame_tick  (frame_tick),
    .game_reset  (game_reset),
    .enemy0_x    (pos_x[0]),
    .enemy0_y    (pos_y[0]),
    .enemy1_x    (pos_x[1]),
    .enemy1_y    (pos_y[1]),
    .enemy2_x    (pos_x[2]),
    .enemy2_y    (pos_y[2]),
    .enemy3_x    (pos_x[3]),
    .enemy3_y    (pos_y[3]),
`ifdef PAC_PROBE_EN
    .pac_x         (pos_x[4]),
    .pac_y         (pos_y[4]),
    .pac_tile_addr (t_addr[4]),
    .pac_tile_code (t_code[4]),
`endif
    .map         (mif),
    .tile0_addr  (t_addr[0]),
    .tile1_addr  (t_addr[1]),
    .tile2_addr  (t_addr[2]),
    .tile3_addr  (t_addr[3]),
    .tile0_code  (t_code[0]),
    .tile1_code  (t_code[1]),
    .tile2_code  (t_code[2]),
    .tile3_code  (t_code[3]),
    .busy        (busy),
    .lookup_done (lookup_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tile under the sprite centre, straight from the geometry rules.
  function automatic int ref_tile(input int x, input int y);
    int col;
    int row;
    col = (x + ENEMY_SIZE / 2) / TILE_W;
    row = (y + ENEMY_SIZE / 2) / TILE_W;
    if (col > MAP_W - 1) col = MAP_W - 1;
    if (row > MAP_H - 1) row = MAP_H - 1;
    return row * MAP_W + col;
  endfunction

  task automatic step();
    @(posedge clk_pix);
    #1;
    if (rand_gnt) mif.map_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    pos_x[i] = 12'(x);
    pos_y[i] = 12'(y);
  endtask

  task automatic latch_expected();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      exp_x[i] = int'(pos_x[i]);
      exp_y[i] = int'(pos_y[i]);
    end
  endtask

  task automatic check_tiles(input string tag);
    int a;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      a = ref_tile(exp_x[i], exp_y[i]);
      check($sformatf("%s_addr%0d", tag, i), 32'(t_addr[i]), 32'(a));
      check($sformatf("%s_code%0d", tag, i), 32'(t_code[i]), 32'(map_mem[a]));
    end
  endtask

  // Tick in the current cycle, wait for lookup_done, verify the published pairs.
  task automatic run_sweep(input string tag, input int want_lat);
    int n;
    latch_expected();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 1;
    while (!lookup_done && n < 400) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, 32'(lookup_done), 32'd1);
    if (want_lat > 0) check({tag, "_latency"}, 32'(n), 32'(want_lat));
    check_tiles(tag);
    step();
    check({tag, "_done_pulse"}, 32'(lookup_done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int first_k;
    bit active;

    for (int i = 0; i < 2048; i++) map_mem[i] = 4'(i);
    for (int i = 0; i < NUM_SLOTS; i++) set_pos(i, 0, 0);
    mif.map_gnt = 1'b1;

    // Reset state.
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(mif.map_req), 32'd0);
    check("rst_map_addr", 32'(mif.map_addr), 32'd0);
    check("rst_done", 32'(lookup_done), 32'd0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      check($sformatf("rst_addr%0d", i), 32'(t_addr[i]), 32'd0);
      check($sformatf("rst_code%0d", i), 32'(t_code[i]), 32'd0);
    end
    rstn = 1'b1;
    step();

    // Screen corners, RAM returns addr[3:0].
    set_pos(0, 0, 0);
    set_pos(1, 1880, 0);
    set_pos(2, 0, 1040);
    set_pos(3, 1880, 1040);
    run_sweep("corners", SWEEP_LAT);
    check("corner_a0", 32'(t_addr[0]), 32'd0);
    check("corner_a1", 32'(t_addr[1]), 32'd47);
    check("corner_a2", 32'(t_addr[2]), 32'd1248);
    check("corner_a3", 32'(t_addr[3]), 32'd1295);
    check("corner_c1", 32'(t_code[1]), 32'd15);
    check("corner_c3", 32'(t_code[3]), 32'd15);

    // Tile-edge and clamp boundaries.
    set_pos(0, 19, 0);
    set_pos(1, 20, 0);
    set_pos(2, 0, 20);
    set_pos(3, 1919, 1079);
    run_sweep("edges", SWEEP_LAT);
    check("edge_x19", 32'(t_addr[0]), 32'd0);
    check("edge_x20", 32'(t_addr[1]), 32'd1);
    check("edge_y20", 32'(t_addr[2]), 32'd48);
    check("edge_clamp", 32'(t_addr[3]), 32'd1295);

    // Grant held low for five cycles during slot 1.
    set_pos(0, 100, 200);
    set_pos(1, 613, 457);
    set_pos(2, 1200, 800);
    set_pos(3, 77, 999);
    latch_expected();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (4) step();
    for (int k = 5; k <= 10; k++) begin
      mif.map_gnt = (k == 10);
      check($sformatf("stall_req_t%0d", k), 32'(mif.map_req), 32'd1);
      check($sformatf("stall_addr_t%0d", k), 32'(mif.map_addr), 32'(ref_tile(exp_x[1], exp_y[1])));
      step();
    end
    n = 11;
    while (!lookup_done && n < 400) begin
      step();
      n++;
    end
    check("stall_latency", 32'(n), 32'(SWEEP_LAT + 5));
    check_tiles("stall");
    step();

    // Second tick while busy: one restart on positions re-latched in DONE.
    for (int i = 0; i < NUM_SLOTS; i++) set_pos(i, 40 * i + 5, 30 * i + 11);
    latch_expected();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) set_pos(i, 300 + 100 * i, 500 - 40 * i);
    repeat (8) step();
    check("pend_first_done", 32'(lookup_done), 32'd1);
    check_tiles("pend_first");
    latch_expected();
    for (int i = 0; i < NUM_SLOTS; i++) old_addr[i] = ref_tile(exp_x[i], exp_y[i]);
    step();
    for (int i = 0; i < NUM_SLOTS; i++) set_pos(i, 1500, 1000);
    pulses = 0;
    first_k = 0;
    for (int k = 14; k < 60; k++) begin
      if (lookup_done) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          check_tiles("pend_second");
        end
      end
      step();
    end
    check("pend_pulses", 32'(pulses), 32'd1);
    check("pend_second_at", 32'(first_k), 32'(2 * SWEEP_LAT));
    check("pend_idle", 32'(busy), 32'd0);

    // game_reset mid-sweep.
    for (int i = 0; i < NUM_SLOTS; i++) set_pos(i, 900 + 50 * i, 100 + 60 * i);
    latch_expected();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (6) step();
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
    check("grst_req", 32'(mif.map_req), 32'd0);
    check("grst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      check($sformatf("grst_code%0d", i), 32'(t_code[i]), 32'd0);
      check($sformatf("grst_addr%0d", i), 32'(t_addr[i]),
            32'((i < 2) ? ref_tile(exp_x[i], exp_y[i]) : old_addr[i]));
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (lookup_done || busy) pulses++;
      step();
    end
    check("grst_quiet", 32'(pulses), 32'd0);
    run_sweep("grst_clean", SWEEP_LAT);

    // Asynchronous rstn during REQ.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("arst_in_req", 32'(mif.map_req), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_req", 32'(mif.map_req), 32'd0);
    check("arst_map_addr", 32'(mif.map_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      check($sformatf("arst_addr%0d", i), 32'(t_addr[i]), 32'd0);
      check($sformatf("arst_code%0d", i), 32'(t_code[i]), 32'd0);
    end
    @(negedge clk_pix);
    rstn = 1'b1;
    active = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy || mif.map_req || lookup_done) active = 1'b1;
    end
    check("arst_quiet", 32'(active), 32'd0);

    // Randomized positions, map contents and grant stalls.
    for (int i = 0; i < 2048; i++) map_mem[i] = 4'($urandom_range(0, 15));
    rand_gnt = 1'b1;
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (s % 4 == 3) set_pos(i, $urandom_range(0, 4095), $urandom_range(0, 4095));
        else            set_pos(i, $urandom_range(0, SCR_W - 1), $urandom_range(0, SCR_H - 1));
      end
      run_sweep($sformatf("rnd%0d", s), 0);
    end
    rand_gnt = 1'b0;
    mif.map_gnt = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
